// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        ADDR,
        DATA,
        CSUM,
        DONE
    } loaderState_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // A length byte of zero encodes a full 256-byte page.
    function automatic logic [8:0] lenToCount(input logic [7:0] n);
        return (n == 8'h00) ? 9'd256 : {1'b0, n};
    endfunction

endpackage

// File: rtl/loader_csum.sv
// 8-bit modulo-256 frame checksum accumulator.
module loader_csum (
    input  logic       clk,
    input  logic       clr,
    input  logic       addEn,
    input  logic [7:0] data,
    output logic [7:0] sum,
    output logic       sumOk
);

    logic [7:0] total;

    always_ff @(posedge clk) begin
        if (clr) begin
            sum <= 8'h00;
        end else if (addEn) begin
            sum <= sum + data;
        end
    end

    assign total = sum + data;
    assign sumOk = (total == 8'h00);

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader: writes payload to memory and holds the core
// in reset until a frame with a good checksum has landed.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       cpu_hold,
    output logic       load_done,
    output logic       load_err
);

    loaderState_t state;
    logic [8:0]   count;
    logic [7:0]   ptr;
    logic [7:0]   sum;
    logic         sumOk;
    logic         accept;
    logic         hunting;
    logic         isSync;
    logic         csumClr;
    logic         csumAdd;

    assign accept  = rx_valid && rx_ready;
    assign hunting = (state == IDLE) || (state == DONE);
    assign isSync  = (rx_data == SYNC_BYTE);
    assign csumClr = reset || (accept && hunting && isSync);
    assign csumAdd = accept &&
                     ((state == LEN) || (state == ADDR) || (state == DATA));

    loader_csum uCsum (
        .clk   (clk),
        .clr   (csumClr),
        .addEn (csumAdd),
        .data  (rx_data),
        .sum   (sum),
        .sumOk (sumOk)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 9'd0;
            ptr       <= 8'h00;
            rx_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 8'h00;
            mem_wdata <= 8'h00;
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            rx_ready <= 1'b1;
            mem_we   <= 1'b0;
            if (accept) begin
                unique case (state)
                    IDLE, DONE: begin
                        if (isSync) begin
                            state     <= LEN;
                            cpu_hold  <= 1'b1;
                            load_done <= 1'b0;
                            load_err  <= 1'b0;
                        end
                    end
                    LEN: begin
                        count <= lenToCount(rx_data);
                        state <= ADDR;
                    end
                    ADDR: begin
                        ptr   <= rx_data;
                        state <= DATA;
                    end
                    DATA: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= ptr;
                        mem_wdata <= rx_data;
                        ptr       <= ptr + 8'd1;
                        count     <= count - 9'd1;
                        if (count == 9'd1) begin
                            state <= CSUM;
                        end
                    end
                    CSUM: begin
                        if (sumOk) begin
                            state     <= DONE;
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            load_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    logic unusedSum;
    assign unusedSum = ^sum;

endmodule

// File: tb/tb_prog_loader.sv
// Directed and randomized frame tests for prog_loader.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;

    prog_loader dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         c;
    } wr_t;

    wr_t seen[$];
    int  cyc = 0;
    int  nTests = 0;
    int  nFail = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_we === 1'b1) seen.push_back('{mem_addr, mem_wdata, cyc});
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b, input bit gap);
        int guard;
        if (gap) repeat ($urandom_range(0, 3)) tick();
        rx_data  = b;
        rx_valid = 1'b1;
        guard = 0;
        while (rx_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) check("ready_timeout", 32'd0, 32'd1);
        tick();
        rx_valid = 1'b0;
    endtask

    // Reference: a frame is sync, len, base, payload, then the byte that
    // makes the 8-bit sum of len+base+payload+csum vanish.
    task automatic runFrame(input string tag, input int len,
                            input logic [7:0] base, input logic [7:0] pay[$],
                            input bit bad, input bit gap);
        logic [7:0] s;
        logic [7:0] cs;
        seen.delete();
        s = 8'(len) + base;
        foreach (pay[i]) s = s + pay[i];
        cs = 8'h00 - s;
        if (bad) cs = cs + 8'(1 + $urandom_range(0, 254));
        sendByte(8'hA5, gap);
        check({tag, "_sync_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_sync_done"}, 32'(load_done), 32'd0);
        check({tag, "_sync_err"}, 32'(load_err), 32'd0);
        sendByte(8'(len), gap);
        sendByte(base, gap);
        foreach (pay[i]) sendByte(pay[i], gap);
        sendByte(cs, gap);
        check({tag, "_nwrites"}, 32'(seen.size()), 32'(len));
        if (seen.size() == len) begin
            for (int i = 0; i < len; i++) begin
                check({tag, "_addr"}, 32'(seen[i].a), 32'((int'(base) + i) % 256));
                check({tag, "_data"}, 32'(seen[i].d), 32'(pay[i]));
                if (!gap) check({tag, "_cycle"}, 32'(seen[i].c - seen[0].c), 32'(i));
            end
        end
        check({tag, "_done"}, 32'(load_done), bad ? 32'd0 : 32'd1);
        check({tag, "_hold"}, 32'(cpu_hold), bad ? 32'd1 : 32'd0);
        check({tag, "_err"}, 32'(load_err), bad ? 32'd1 : 32'd0);
    endtask

    initial begin
        logic [7:0] p[$];

        repeat (3) tick();
        check("rst_ready", 32'(rx_ready), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        reset = 1'b0;
        tick();
        check("rst_ready_rise", 32'(rx_ready), 32'd1);

        p = '{8'h11, 8'h22, 8'h33};
        runFrame("basic", 3, 8'h10, p, 1'b0, 1'b0);

        p = '{8'h01, 8'h02};
        runFrame("wrap", 2, 8'hFF, p, 1'b0, 1'b0);

        p.delete();
        for (int i = 0; i < 256; i++) p.push_back(8'h01);
        runFrame("n256", 256, 8'h00, p, 1'b0, 1'b0);

        p = '{8'h11, 8'h22, 8'h33};
        runFrame("badcs", 3, 8'h10, p, 1'b1, 1'b0);
        runFrame("afterbad", 3, 8'h10, p, 1'b0, 1'b0);

        seen.delete();
        sendByte(8'h00, 1'b0);
        sendByte(8'hFF, 1'b0);
        sendByte(8'h5A, 1'b0);
        check("garbage_nowrite", 32'(seen.size()), 32'd0);
        runFrame("garbage", 3, 8'h10, p, 1'b0, 1'b0);
        runFrame("gaps", 3, 8'h10, p, 1'b0, 1'b1);

        seen.delete();
        sendByte(8'hA5, 1'b0);
        sendByte(8'h03, 1'b0);
        sendByte(8'h10, 1'b0);
        sendByte(8'h11, 1'b0);
        sendByte(8'h22, 1'b0);
        reset = 1'b1;
        tick();
        check("midrst_ready", 32'(rx_ready), 32'd0);
        check("midrst_we", 32'(mem_we), 32'd0);
        check("midrst_addr", 32'(mem_addr), 32'd0);
        check("midrst_wdata", 32'(mem_wdata), 32'd0);
        check("midrst_hold", 32'(cpu_hold), 32'd1);
        check("midrst_done", 32'(load_done), 32'd0);
        check("midrst_err", 32'(load_err), 32'd0);
        check("midrst_partial", 32'(seen.size()), 32'd2);
        reset = 1'b0;
        tick();
        runFrame("postrst", 3, 8'h10, p, 1'b0, 1'b0);
        runFrame("reload", 3, 8'h40, p, 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            int len;
            len = $urandom_range(1, 40);
            p.delete();
            for (int i = 0; i < len; i++) p.push_back(8'($urandom));
            runFrame("rand", len, 8'($urandom), p,
                     ($urandom_range(0, 3) == 0), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
